// File: rtl/vdp_vga_timing_if.sv
// rtl/vdp_vga_timing_if.sv - VGA timing output bundle between timing generator and VDP pixel logic
interface vdp_vga_timing_if;
    logic       hsync;
    logic       vsync;
    logic       vid_active;
    logic       bdr_active;
    logic       last_pixel;
    logic       col_last;
    logic       row_last;
    logic [8:0] px_col;
    logic [9:0] px_row;

    modport master (
        output hsync, vsync, vid_active, bdr_active,
        output last_pixel, col_last, row_last, px_col, px_row
    );

    modport slave (
        input hsync, vsync, vid_active, bdr_active,
        input last_pixel, col_last, row_last, px_col, px_row
    );
endinterface

// File: rtl/vdp_vga_timing.sv
// rtl/vdp_vga_timing.sv - 640x480@60 VGA timing with centred 512x384 VDP window
// Optional border-region decode is enabled by defining VDP_BORDER_EN.
module vdp_vga_timing (
    input  logic              pxclk,
    input  logic              reset,
    vdp_vga_timing_if.master  vga
);

    localparam logic [9:0] H_LAST      = 10'd799;
    localparam logic [9:0] H_VISIBLE   = 10'd640;
    localparam logic [9:0] H_SYNC_FROM = 10'd656;
    localparam logic [9:0] H_SYNC_TO   = 10'd751;
    localparam logic [9:0] WIN_COL_LO  = 10'd64;
    localparam logic [9:0] WIN_COL_HI  = 10'd575;

    localparam logic [9:0] V_LAST      = 10'd524;
    localparam logic [9:0] V_VISIBLE   = 10'd480;
    localparam logic [9:0] V_SYNC_FROM = 10'd490;
    localparam logic [9:0] V_SYNC_TO   = 10'd491;
    localparam logic [9:0] WIN_ROW_LO  = 10'd48;
    localparam logic [9:0] WIN_ROW_HI  = 10'd431;

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       vid_q, vid_d;
    logic       last_pixel_q, last_pixel_d;
    logic       col_last_q, col_last_d;
    logic       row_last_q, row_last_d;
    logic [8:0] px_col_q, px_col_d;
    logic [9:0] px_row_q, px_row_d;
    logic [9:0] col_off;
    logic [9:0] row_off;

    always_comb begin
        col_d = col_q + 10'd1;
        row_d = row_q;
        if (col_q == H_LAST) begin
            col_d = 10'd0;
            row_d = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
        end
    end

    // Outputs decode the next position so the registered value lines up with the counters.
    always_comb begin
        col_off      = col_d - WIN_COL_LO;
        row_off      = row_d - WIN_ROW_LO;
        hsync_d      = !((col_d >= H_SYNC_FROM) && (col_d <= H_SYNC_TO));
        vsync_d      = !((row_d >= V_SYNC_FROM) && (row_d <= V_SYNC_TO));
        vid_d        = (col_d >= WIN_COL_LO) && (col_d <= WIN_COL_HI) &&
                       (row_d >= WIN_ROW_LO) && (row_d <= WIN_ROW_HI);
        col_last_d   = (col_d == H_LAST);
        row_last_d   = (row_d == V_LAST);
        last_pixel_d = col_last_d && row_last_d;
        px_col_d     = vid_d ? col_off[9:1] : 9'd0;
        px_row_d     = vid_d ? {1'b0, row_off[9:1]} : 10'd0;
    end

    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            col_q        <= 10'd0;
            row_q        <= 10'd0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            vid_q        <= 1'b0;
            last_pixel_q <= 1'b0;
            col_last_q   <= 1'b0;
            row_last_q   <= 1'b0;
            px_col_q     <= 9'd0;
            px_row_q     <= 10'd0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            vid_q        <= vid_d;
            last_pixel_q <= last_pixel_d;
            col_last_q   <= col_last_d;
            row_last_q   <= row_last_d;
            px_col_q     <= px_col_d;
            px_row_q     <= px_row_d;
        end
    end

`ifdef VDP_BORDER_EN
    logic bdr_q, bdr_d;

    always_comb begin
        bdr_d = (col_d < H_VISIBLE) && (row_d < V_VISIBLE) && !vid_d;
    end

    // Reset position (0,0) is a border pixel, so the border flag resets high.
    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            bdr_q <= 1'b1;
        end else begin
            bdr_q <= bdr_d;
        end
    end

    assign vga.bdr_active = bdr_q;
`else
    assign vga.bdr_active = 1'b0;
`endif

    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.vid_active = vid_q;
    assign vga.last_pixel = last_pixel_q;
    assign vga.col_last   = col_last_q;
    assign vga.row_last   = row_last_q;
    assign vga.px_col     = px_col_q;
    assign vga.px_row     = px_row_q;

endmodule

// File: tb/tb_vdp_vga_timing.sv
// tb/tb_vdp_vga_timing.sv - randomized reset-timing bench against a frame-position model
module tb_vdp_vga_timing;

    logic pxclk;
    logic reset;

    vdp_vga_timing_if vga ();

    vdp_vga_timing dut (
        .pxclk (pxclk),
        .reset (reset),
        .vga   (vga)
    );

    initial pxclk = 1'b0;
    always #20 pxclk = ~pxclk;

    int          n_checks;
    int          n_fails;
    int unsigned t;

    bit          stats_on;
    int          hs_low_cnt;
    int          hs_first_col;
    int          vid_first_col;
    int          pxc_at_575;
    int          vid_at_576;
    int          cl_cnt;
    int          both_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [31:0] outs();
        return {6'd0, vga.hsync, vga.vsync, vga.vid_active, vga.bdr_active,
                vga.last_pixel, vga.col_last, vga.row_last, vga.px_col, vga.px_row};
    endfunction

    // Reference: position is simply elapsed cycles since reset release, folded into the frame.
    function automatic logic [31:0] model(input int unsigned tt);
        int   col, row;
        logic hs, vs, vid, bdr, cl, rl;
        logic [8:0] pxc;
        logic [9:0] pxr;
        col = int'(tt % 800);
        row = int'((tt / 800) % 525);
        hs  = !(col >= 656 && col < 656 + 96);
        vs  = !(row == 490 || row == 491);
        vid = (col >= 64 && col < 64 + 512 && row >= 48 && row < 48 + 384);
`ifdef VDP_BORDER_EN
        bdr = (col < 640 && row < 480 && !vid);
`else
        bdr = 1'b0;
`endif
        cl  = (col == 799);
        rl  = (row == 524);
        pxc = vid ? 9'((col - 64) / 2) : 9'd0;
        pxr = vid ? 10'((row - 48) / 2) : 10'd0;
        return {6'd0, hs, vs, vid, bdr, cl && rl, cl, rl, pxc, pxr};
    endfunction

    task automatic run(input int n);
        int col, row;
        for (int i = 0; i < n; i++) begin
            @(posedge pxclk);
            t++;
            #1;
            check("cycle", outs(), model(t));
            if (stats_on) begin
                col = int'(t % 800);
                row = int'((t / 800) % 525);
                if (row == 10 && !vga.hsync) begin
                    hs_low_cnt++;
                    if (hs_first_col < 0) hs_first_col = col;
                end
                if (row == 48 && vga.vid_active && vid_first_col < 0) begin
                    vid_first_col = col;
                    check("px_at_win_start", {vga.px_col, vga.px_row}, 19'd0);
                end
                if (row == 48 && col == 575) pxc_at_575 = int'(vga.px_col);
                if (row == 48 && col == 576) vid_at_576 = int'(vga.vid_active);
                if (vga.col_last) cl_cnt++;
                if (vga.vid_active && vga.bdr_active) both_cnt++;
            end
        end
    endtask

    task automatic release_reset();
        @(negedge pxclk);
        reset = 1'b1;
        t = 0;
    endtask

    initial begin
        int dly;
        int hold;
        n_checks      = 0;
        n_fails       = 0;
        t             = 0;
        stats_on      = 1'b0;
        hs_low_cnt    = 0;
        hs_first_col  = -1;
        vid_first_col = -1;
        pxc_at_575    = -1;
        vid_at_576    = -1;
        cl_cnt        = 0;
        both_cnt      = 0;

        reset = 1'b0;
        repeat (4) @(posedge pxclk);
        #1;
        check("reset_hold", outs(), model(0));
        release_reset();

        stats_on = 1'b1;
        run(45000);
        stats_on = 1'b0;
        check("hs_low_len_row10", 32'(hs_low_cnt), 32'd96);
        check("hs_first_col_row10", 32'(hs_first_col), 32'd656);
        check("vid_first_col_row48", 32'(vid_first_col), 32'd64);
        check("px_col_at_575", 32'(pxc_at_575), 32'd255);
        check("vid_at_576", 32'(vid_at_576), 32'd0);
        check("col_last_pulses", 32'(cl_cnt), 32'((45000 + 1) / 800));
        check("vid_and_bdr", 32'(both_cnt), 32'd0);

        for (int k = 0; k < 6; k++) begin
            run(int'($urandom_range(50, 3000)));
            @(posedge pxclk);
            t++;
            #1;
            check("pre_async", outs(), model(t));
            dly = int'($urandom_range(2, 15));
            #(dly);
            reset = 1'b0;
            #1;
            check("async_reset", outs(), model(0));
            hold = int'($urandom_range(1, 4));
            repeat (hold) begin
                @(posedge pxclk);
                #1;
                check("reset_hold", outs(), model(0));
            end
            release_reset();
        end

        run(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vdp_vga_timing.md
VDP_VGA_TIMING -- requirements
Module: vdp_vga_timing

Interface
REQ-001 Parameters: none; timing is fixed at 640x480@60 Hz on a 25 MHz pixel clock.
REQ-002 pxclk  input  1  pixel clock, 25 MHz; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 hsync  output  1  horizontal sync, active-low.
REQ-005 vsync  output  1  vertical sync, active-low.
REQ-006 vid_active  output  1  high inside the 512x384 VDP pixel window.
REQ-007 bdr_active  output  1  high inside the 640x480 visible area but outside the VDP window.
REQ-008 last_pixel  output  1  high on the final pixel of the frame (col 799, row 524).
REQ-009 col_last  output  1  high on the final pixel of every line (col 799).
REQ-010 row_last  output  1  high on every pixel of the final line (row 524).
REQ-011 px_col  output  9  VDP column 0..255 inside the window, 0 outside.
REQ-012 px_row  output  10  VDP row 0..191 inside the window, 0 outside; width matches vdp_fsm px_row.

Function
REQ-013 Internal column counter col 0..799 SHALL increment each pxclk and wrap 799->0.
REQ-014 Internal row counter row 0..524 SHALL increment only when col wraps, and SHALL wrap 524->0 in the same cycle col wraps.
REQ-015 Horizontal: visible col 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 Vertical: visible row 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 hsync SHALL be 0 exactly for col 656..751 on every row, including vertical blanking rows.
REQ-018 vsync SHALL be 0 exactly for row 490..491, all 800 columns of each.
REQ-019 VDP window: col 64..575 and row 48..431; vid_active SHALL be 1 iff (col,row) lies inside it.
REQ-020 bdr_active SHALL be 1 iff col<640, row<480 and vid_active=0; vid_active and bdr_active SHALL never both be 1.
REQ-021 px_col SHALL equal (col-64)>>1 and px_row SHALL equal (row-48)>>1 while vid_active=1; both SHALL be 0 otherwise. Each VDP pixel is therefore two clocks wide and two lines tall.
REQ-022 All outputs SHALL be registered.
REQ-023 Outputs SHALL be computed from the next counter values, so that in any cycle every output describes the current (col,row) with zero latency.
REQ-024 last_pixel SHALL equal col_last AND row_last and SHALL be high for exactly 1 cycle per 420000-cycle frame.
REQ-025 No input other than reset SHALL affect the sequence; the frame period SHALL be exactly 800x525 cycles.

Reset
REQ-026 While reset=0, the counters SHALL hold col=0, row=0.
REQ-027 While reset=0, outputs SHALL hold hsync=1, vsync=1, vid_active=0, bdr_active=1 (0 if VDP_BORDER_EN is undefined), last_pixel=0, col_last=0, row_last=0, px_col=0, px_row=0.
REQ-028 Reset assertion mid-frame SHALL take effect immediately (asynchronous) and SHALL abort the frame.
REQ-029 On the first rising pxclk after reset deasserts, the counters SHALL advance to col=1, row=0.

Configuration
REQ-030 Macro VDP_BORDER_EN defined: bdr_active SHALL behave per REQ-020.
REQ-031 Macro VDP_BORDER_EN undefined: bdr_active SHALL be tied to 0 and the border-region decode SHALL be omitted; all other outputs SHALL be unchanged.

Verification
REQ-032 Scenario: hold reset=0 for 4 clocks, then check outputs; release reset -> outputs match REQ-027, and col=1 one clock after release.
REQ-033 Scenario: run 2 full frames, count cycles between last_pixel pulses -> exactly 420000; col_last pulses per frame -> 525.
REQ-034 Scenario: sample row 10 -> hsync low for exactly 96 cycles starting at col 656; vsync low for exactly 1600 consecutive cycles starting at row 490, col 0.
REQ-035 Scenario: sample row 48, then row 431 -> vid_active first high at col 64 with px_col=0, px_row=0; px_col=255 at col 575; vid_active low at col 576; px_row=191 on row 431.
REQ-036 Scenario: with VDP_BORDER_EN defined, check (col 0,row 0), (col 639,row 479) and (col 640,row 0) -> bdr_active=1, 1, 0 respectively; vid_active&bdr_active never 1 over a full frame. With the macro undefined -> bdr_active=0 for the entire frame.
REQ-037 Scenario: assert reset at row 200, col 300 -> outputs take reset values within the same cycle; after release, the next last_pixel occurs after exactly 419999 clocks.
